// File: rtl/eq_search_pkg.sv
// Shared types and constants for the serial CAM lookup sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package eq_search_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 8;

    // Code 2'd3 is unused; the FSM treats it as illegal and falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width for a table of 'depth' entries; never narrower than one bit.
    function automatic int iw_of(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/eq_cmp.sv
// WIDTH-bit equality comparator shaped as a LUT + carry-mux chain (2 bits per LUT, carry-in = 1).
// Latency: purely combinational.
// Backpressure: none (no handshake).
module eq_cmp #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq
);

    localparam int NPAIR = (WIDTH + 1) / 2;
    localparam int PW    = 2 * NPAIR;

    logic [PW-1:0]    a_pad;
    logic [PW-1:0]    b_pad;
    logic [NPAIR-1:0] lut_o;
    logic             carry;

    // Zero-pad an odd width so every LUT sees a full bit pair; padded bits always match.
    always_comb begin
        a_pad            = '0;
        b_pad            = '0;
        a_pad[WIDTH-1:0] = a;
        b_pad[WIDTH-1:0] = b;
    end

    // One LUT per bit pair: high when both bits of the pair match.
    always_comb begin
        lut_o = '0;
        for (int p = 0; p < NPAIR; p++) begin
            lut_o[p] = (a_pad[2*p +: 2] == b_pad[2*p +: 2]);
        end
    end

    // Carry chain: each mux passes the carry when its LUT matches, else forces 0.
    always_comb begin
        carry = 1'b1;
        for (int p = 0; p < NPAIR; p++) begin
            carry = lut_o[p] ? carry : 1'b0;
        end
        eq = carry;
    end

endmodule

// File: rtl/eq_search_seq.sv
// Serial CAM lookup: scans valid table entries from index 0 through one shared comparator.
// Latency: hit at index k -> RVALID in t0+2+k; miss -> t0+1+DEPTH (t0 = acceptance cycle).
// Backpressure: result held in DONE until RREADY; SREADY only high in IDLE, requests are not queued.
module eq_search_seq
    import eq_search_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int IW    = iw_of(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WE,
    input  logic [IW-1:0]    WADDR,
    input  logic [WIDTH-1:0] WDATA,
    input  logic             CLR,
    input  logic             SVALID,
    output logic             SREADY,
    input  logic [WIDTH-1:0] SKEY,
    output logic             RVALID,
    input  logic             RREADY,
    output logic             RHIT,
    output logic [IW-1:0]    RINDEX
);

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] tbl [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_nxt;

    logic [WIDTH-1:0] key_q;
    logic [IW-1:0]    idx_q;
    logic             rhit_q;
    logic [IW-1:0]    rindex_q;

    logic             cmp_eq;
    logic             hit;
    logic             last;
    logic             accept;

    // The single comparator shared by every table entry over the course of a scan.
    eq_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a  (tbl[idx_q]),
        .b  (key_q),
        .eq (cmp_eq)
    );

    assign hit    = vld_q[idx_q] & cmp_eq;
    assign last   = (idx_q == IW'(DEPTH - 1));
    assign RHIT   = rhit_q;
    assign RINDEX = rindex_q;

    // Entry storage: data is never reset, only its valid bit matters.
    always_ff @(posedge CLK) begin
        if (WE) begin
            tbl[WADDR] <= WDATA;
        end
    end

    // Valid bits: CLR wipes first, so a same-cycle write still lands as valid.
    always_comb begin
        vld_nxt = CLR ? '0 : vld_q;
        if (WE) begin
            vld_nxt[WADDR] = 1'b1;
        end
    end

    // Valid-bit register; reset invalidates the whole table.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_nxt;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; SREADY/RVALID decode the state register only.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        SREADY    = 1'b0;
        RVALID    = 1'b0;
        case (state)
            IDLE: begin
                SREADY = 1'b1;
                if (SVALID) begin
                    accept    = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (hit || last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                RVALID = 1'b1;
                if (RREADY) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Key capture, scan index walk and result registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            key_q    <= '0;
            idx_q    <= '0;
            rhit_q   <= 1'b0;
            rindex_q <= '0;
        end else if (accept) begin
            key_q <= SKEY;
            idx_q <= '0;
        end else if (state == SCAN) begin
            if (hit) begin
                rhit_q   <= 1'b1;
                rindex_q <= idx_q;
            end else if (last) begin
                rhit_q   <= 1'b0;
                rindex_q <= '0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eq_search_seq.sv
module tb_eq_search_seq;

    logic       CLK;
    logic       RESET;
    logic       WE;
    logic [2:0] WADDR;
    logic [3:0] WDATA;
    logic       CLR;
    logic       SVALID;
    logic       SREADY;
    logic [3:0] SKEY;
    logic       RVALID;
    logic       RREADY;
    logic       RHIT;
    logic [2:0] RINDEX;

    int cyc;
    int chk_cnt;
    int pass_cnt;

    eq_search_seq #(
        .WIDTH (4),
        .DEPTH (8)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .WE     (WE),
        .WADDR  (WADDR),
        .WDATA  (WDATA),
        .CLR    (CLR),
        .SVALID (SVALID),
        .SREADY (SREADY),
        .SKEY   (SKEY),
        .RVALID (RVALID),
        .RREADY (RREADY),
        .RHIT   (RHIT),
        .RINDEX (RINDEX)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [3:0] d);
        WE = 1'b1; WADDR = a; WDATA = d;
        step();
        WE = 1'b0;
    endtask

    // Presents the key in cycle t0 (DUT is in IDLE); returns in cycle t0+1 with cyc = 1.
    task automatic start_search(input logic [3:0] key);
        SVALID = 1'b1; SKEY = key; cyc = 0;
        step();
        SVALID = 1'b0; SKEY = ~key;
    endtask

    // Advances until RVALID (bounded); cyc then holds the cycle offset from t0.
    task automatic wait_result();
        while (RVALID !== 1'b1 && cyc < 40) step();
    endtask

    task automatic consume();
        RREADY = 1'b1;
        step();
        RREADY = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; WE = 1'b0; WADDR = '0; WDATA = '0; CLR = 1'b0;
        SVALID = 1'b0; SKEY = '0; RREADY = 1'b0; cyc = 0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk_cnt++; if (SREADY !== 1'b1) $display("FAIL rst_sready: got %b want 1", SREADY); else pass_cnt++;
        chk_cnt++; if (RVALID !== 1'b0) $display("FAIL rst_rvalid: got %b want 0", RVALID); else pass_cnt++;
        chk_cnt++; if (RHIT !== 1'b0) $display("FAIL rst_rhit: got %b want 0", RHIT); else pass_cnt++;
        chk_cnt++; if (RINDEX !== 3'd0) $display("FAIL rst_rindex: got %0d want 0", RINDEX); else pass_cnt++;
        start_search(4'h5);
        wait_result();
        chk_cnt++; if (cyc != 9) $display("FAIL empty_latency: got t0+%0d want t0+9", cyc); else pass_cnt++;
        chk_cnt++; if (RHIT !== 1'b0) $display("FAIL empty_rhit: got %b want 0", RHIT); else pass_cnt++;
        chk_cnt++; if (RINDEX !== 3'd0) $display("FAIL empty_rindex: got %0d want 0", RINDEX); else pass_cnt++;
        consume();
        chk_cnt++; if (RVALID !== 1'b0 || SREADY !== 1'b1) $display("FAIL empty_consume: got rvalid=%b sready=%b want 0/1", RVALID, SREADY); else pass_cnt++;
    endtask

    task automatic test_hit_latency();
        write_entry(3'd3, 4'hA);
        write_entry(3'd6, 4'hA);
        start_search(4'hA);
        wait_result();
        chk_cnt++; if (cyc != 5) $display("FAIL hit3_latency: got t0+%0d want t0+5", cyc); else pass_cnt++;
        chk_cnt++; if (RHIT !== 1'b1) $display("FAIL hit3_rhit: got %b want 1", RHIT); else pass_cnt++;
        chk_cnt++; if (RINDEX !== 3'd3) $display("FAIL hit3_rindex: got %0d want 3", RINDEX); else pass_cnt++;
        consume();
        start_search(4'hB);
        wait_result();
        chk_cnt++; if (cyc != 9) $display("FAIL missB_latency: got t0+%0d want t0+9", cyc); else pass_cnt++;
        chk_cnt++; if (RHIT !== 1'b0 || RINDEX !== 3'd0) $display("FAIL missB_result: got hit=%b idx=%0d want 0/0", RHIT, RINDEX); else pass_cnt++;
        consume();
    endtask

    task automatic test_backpressure();
        write_entry(3'd0, 4'h3);
        start_search(4'h3);
        wait_result();
        chk_cnt++; if (cyc != 2) $display("FAIL hit0_latency: got t0+%0d want t0+2", cyc); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            SVALID = 1'b1; SKEY = 4'h3;
            step();
            chk_cnt++; if (RVALID !== 1'b1 || RHIT !== 1'b1 || RINDEX !== 3'd0 || SREADY !== 1'b0)
                $display("FAIL hold_%0d: got rvalid=%b hit=%b idx=%0d sready=%b want 1/1/0/0", i, RVALID, RHIT, RINDEX, SREADY);
            else pass_cnt++;
        end
        SVALID = 1'b0;
        consume();
        chk_cnt++; if (RVALID !== 1'b0 || SREADY !== 1'b1) $display("FAIL bp_release: got rvalid=%b sready=%b want 0/1", RVALID, SREADY); else pass_cnt++;
        step();
        chk_cnt++; if (SREADY !== 1'b1) $display("FAIL bp_not_queued: got sready=%b want 1", SREADY); else pass_cnt++;
    endtask

    task automatic test_midscan_write();
        write_entry(3'd5, 4'h7);
        start_search(4'h7);
        step(); step();
        WE = 1'b1; WADDR = 3'd5; WDATA = 4'h1;
        step();
        WE = 1'b0;
        wait_result();
        chk_cnt++; if (cyc != 9 || RHIT !== 1'b0) $display("FAIL overwrite5: got t0+%0d hit=%b want t0+9/0", cyc, RHIT); else pass_cnt++;
        consume();
        start_search(4'h7);
        step(); step(); step(); step();
        WE = 1'b1; WADDR = 3'd1; WDATA = 4'h7;
        step();
        WE = 1'b0;
        wait_result();
        chk_cnt++; if (cyc != 9 || RHIT !== 1'b0) $display("FAIL passed1: got t0+%0d hit=%b want t0+9/0", cyc, RHIT); else pass_cnt++;
        consume();
        start_search(4'h7);
        wait_result();
        chk_cnt++; if (cyc != 3 || RHIT !== 1'b1 || RINDEX !== 3'd1) $display("FAIL after_write1: got t0+%0d hit=%b idx=%0d want t0+3/1/1", cyc, RHIT, RINDEX); else pass_cnt++;
        consume();
    endtask

    task automatic test_clr();
        write_entry(3'd4, 4'h9);
        start_search(4'h9);
        step();
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        wait_result();
        chk_cnt++; if (cyc != 9 || RHIT !== 1'b0) $display("FAIL clr_midscan: got t0+%0d hit=%b want t0+9/0", cyc, RHIT); else pass_cnt++;
        consume();
        CLR = 1'b1;
        write_entry(3'd2, 4'hC);
        CLR = 1'b0;
        start_search(4'hC);
        wait_result();
        chk_cnt++; if (cyc != 4 || RHIT !== 1'b1 || RINDEX !== 3'd2) $display("FAIL we_clr_hit: got t0+%0d hit=%b idx=%0d want t0+4/1/2", cyc, RHIT, RINDEX); else pass_cnt++;
        consume();
        start_search(4'hA);
        wait_result();
        chk_cnt++; if (cyc != 9 || RHIT !== 1'b0) $display("FAIL we_clr_othersA: got t0+%0d hit=%b want t0+9/0", cyc, RHIT); else pass_cnt++;
        consume();
        start_search(4'h7);
        wait_result();
        chk_cnt++; if (cyc != 9 || RHIT !== 1'b0) $display("FAIL we_clr_others7: got t0+%0d hit=%b want t0+9/0", cyc, RHIT); else pass_cnt++;
        consume();
    endtask

    task automatic test_reset_midscan();
        write_entry(3'd7, 4'hE);
        start_search(4'hE);
        step(); step(); step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk_cnt++; if (SREADY !== 1'b1 || RVALID !== 1'b0) $display("FAIL rstmid_state: got sready=%b rvalid=%b want 1/0", SREADY, RVALID); else pass_cnt++;
        chk_cnt++; if (RHIT !== 1'b0 || RINDEX !== 3'd0) $display("FAIL rstmid_result: got hit=%b idx=%0d want 0/0", RHIT, RINDEX); else pass_cnt++;
        repeat (8) step();
        chk_cnt++; if (RVALID !== 1'b0 || SREADY !== 1'b1) $display("FAIL rstmid_abandon: got rvalid=%b sready=%b want 0/1", RVALID, SREADY); else pass_cnt++;
        start_search(4'hE);
        wait_result();
        chk_cnt++; if (cyc != 9 || RHIT !== 1'b0) $display("FAIL rstmid_missE: got t0+%0d hit=%b want t0+9/0", cyc, RHIT); else pass_cnt++;
        consume();
        start_search(4'hC);
        wait_result();
        chk_cnt++; if (cyc != 9 || RHIT !== 1'b0) $display("FAIL rstmid_missC: got t0+%0d hit=%b want t0+9/0", cyc, RHIT); else pass_cnt++;
        consume();
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        test_reset();
        test_hit_latency();
        test_backpressure();
        test_midscan_write();
        test_clr();
        test_reset_midscan();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
